// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: combinational decode of the fetch word into a registered 2-entry
// skid buffer with valid/ready on both sides, flush, and a saturating illegal counter.
module rv32_decode_stage #(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_M   = 1'b1,
  parameter bit          ENABLE_SYS = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [3:0]       out_mini_op,
  output logic [1:0]       out_alu_op,
  output logic [2:0]       out_imm_sel,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] MiniR       = 4'b0000;
  localparam logic [3:0] MiniIL      = 4'b0001;
  localparam logic [3:0] MiniIC      = 4'b0010;
  localparam logic [3:0] MiniJalr    = 4'b0011;
  localparam logic [3:0] MiniS       = 4'b0100;
  localparam logic [3:0] MiniB       = 4'b0101;
  localparam logic [3:0] MiniLui     = 4'b0110;
  localparam logic [3:0] MiniAuipc   = 4'b0111;
  localparam logic [3:0] MiniJal     = 4'b1000;
  localparam logic [3:0] MiniSys     = 4'b1001;
  localparam logic [3:0] MiniFence   = 4'b1010;
  localparam logic [3:0] MiniMuldiv  = 4'b1011;
  localparam logic [3:0] MiniIllegal = 4'b1111;

  localparam logic [4:0] OpcOp     = 5'b01100;
  localparam logic [4:0] OpcLoad   = 5'b00000;
  localparam logic [4:0] OpcOpImm  = 5'b00100;
  localparam logic [4:0] OpcJalr   = 5'b11001;
  localparam logic [4:0] OpcStore  = 5'b01000;
  localparam logic [4:0] OpcBranch = 5'b11000;
  localparam logic [4:0] OpcLui    = 5'b01101;
  localparam logic [4:0] OpcAuipc  = 5'b00101;
  localparam logic [4:0] OpcJal    = 5'b11011;
  localparam logic [4:0] OpcSystem = 5'b11100;
  localparam logic [4:0] OpcMisc   = 5'b00011;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [3:0]      mini_op;
    logic [1:0]      alu_op;
    logic [2:0]      imm_sel;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [4:0]  opcode;
  logic [6:0]  funct7;
  logic [3:0]  dec_mini_op;
  logic [1:0]  dec_alu_op;
  logic [2:0]  dec_imm_sel;
  logic [31:0] dec_imm32;
  entry_t      dec;

  assign opcode = in_instr[6:2];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec_mini_op = MiniIllegal;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        OpcOp: begin
          if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
            dec_mini_op = MiniR;
          end else if (ENABLE_M && funct7 == 7'b0000001) begin
            dec_mini_op = MiniMuldiv;
          end
        end
        OpcLoad:   dec_mini_op = MiniIL;
        OpcOpImm:  dec_mini_op = MiniIC;
        OpcJalr:   dec_mini_op = MiniJalr;
        OpcStore:  dec_mini_op = MiniS;
        OpcBranch: dec_mini_op = MiniB;
        OpcLui:    dec_mini_op = MiniLui;
        OpcAuipc:  dec_mini_op = MiniAuipc;
        OpcJal:    dec_mini_op = MiniJal;
        OpcSystem: if (ENABLE_SYS) dec_mini_op = MiniSys;
        OpcMisc:   if (ENABLE_SYS) dec_mini_op = MiniFence;
        default:   dec_mini_op = MiniIllegal;
      endcase
    end
  end

  always_comb begin
    dec_alu_op = 2'b00;
    case (dec_mini_op)
      MiniR, MiniMuldiv: dec_alu_op = 2'b01;
      MiniLui:           dec_alu_op = 2'b10;
      MiniIC:            dec_alu_op = 2'b11;
      default:           dec_alu_op = 2'b00;
    endcase
  end

  // Immediates are built at 32 bits, then sign-extended to XLEN
  always_comb begin
    dec_imm_sel = ImmI;
    dec_imm32   = '0;
    case (dec_mini_op)
      MiniIL, MiniIC, MiniJalr, MiniSys, MiniFence: begin
        dec_imm_sel = ImmI;
        dec_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      MiniS: begin
        dec_imm_sel = ImmS;
        dec_imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      MiniB: begin
        dec_imm_sel = ImmB;
        dec_imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
      end
      MiniLui, MiniAuipc: begin
        dec_imm_sel = ImmU;
        dec_imm32   = {in_instr[31:12], 12'b0};
      end
      MiniJal: begin
        dec_imm_sel = ImmJ;
        dec_imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
      end
      default: begin
        dec_imm_sel = ImmI;
        dec_imm32   = '0;
      end
    endcase
  end

  always_comb begin
    dec.pc      = in_pc;
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.funct3  = in_instr[14:12];
    dec.mini_op = dec_mini_op;
    dec.alu_op  = dec_alu_op;
    dec.imm_sel = dec_imm_sel;
    dec.imm     = XLEN'($signed(dec_imm32));
    dec.illegal = (dec_mini_op == MiniIllegal);
  end

  // ---------------------------------------------------------------------------
  // Two-entry skid buffer: head_q drives the outputs, skid_q holds the second entry
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, pop;

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready_q & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            head_d  = dec;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            head_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_d = skid_q;
            if (accept) begin
              skid_d = dec;
            end else begin
              state_d = StOne;
            end
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    // Registered ready: looks only at next occupancy, never at out_ready combinationally
    in_ready_d = (state_d != StFull);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec.illegal && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_pc      = head_q.pc;
  assign out_rd      = head_q.rd;
  assign out_rs1     = head_q.rs1;
  assign out_rs2     = head_q.rs2;
  assign out_funct3  = head_q.funct3;
  assign out_mini_op = head_q.mini_op;
  assign out_alu_op  = head_q.alu_op;
  assign out_imm_sel = head_q.imm_sel;
  assign out_imm     = head_q.imm;
  assign out_illegal = head_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Scoreboard bench for rv32_decode_stage: two instances (full ISA / base-only with 2-bit
// counter) share one stimulus stream and are checked against a behavioural model.
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid;
  logic [31:0] in_instr, in_pc;
  logic        out_ready, rdy_mode, rdy_force, rnd_rdy;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3, a_sel;
  logic [3:0]  a_mini;
  logic [1:0]  a_alu;
  logic [7:0]  a_cnt;

  logic        b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3, b_sel;
  logic [3:0]  b_mini;
  logic [1:0]  b_alu;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;
  assign out_ready = rdy_mode ? rnd_rdy : rdy_force;

  rv32_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_SYS(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_funct3(a_f3),
    .out_mini_op(a_mini), .out_alu_op(a_alu), .out_imm_sel(a_sel), .out_imm(a_imm),
    .out_illegal(a_ill), .illegal_cnt(a_cnt)
  );

  rv32_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_SYS(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct3(b_f3),
    .out_mini_op(b_mini), .out_alu_op(b_alu), .out_imm_sel(b_sel), .out_imm(b_imm),
    .out_illegal(b_ill), .illegal_cnt(b_cnt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  mini;
    logic [1:0]  alu;
    logic [2:0]  sel;
    logic [31:0] imm;
    logic        ill;
  } f_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } txn_t;

  txn_t sbq[$];
  f_t   disp_a, disp_b;
  int   m_cnt_a, m_cnt_b;
  int   n_chk = 0, n_fail = 0;
  bit   started = 0, aborted = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the ISA field layout, immediates by arithmetic on the fields
  function automatic f_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                    input bit en_m, input bit en_sys);
    f_t e;
    int cls, v;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12];
    cls = 15;
    if (w[1:0] == 2'b11) begin
      case (w[6:2])
        5'b01100: begin
          if (w[31:25] == 7'h00 || w[31:25] == 7'h20) cls = 0;
          else if (w[31:25] == 7'h01 && en_m) cls = 11;
        end
        5'b00000: cls = 1;
        5'b00100: cls = 2;
        5'b11001: cls = 3;
        5'b01000: cls = 4;
        5'b11000: cls = 5;
        5'b01101: cls = 6;
        5'b00101: cls = 7;
        5'b11011: cls = 8;
        5'b11100: if (en_sys) cls = 9;
        5'b00011: if (en_sys) cls = 10;
        default:  cls = 15;
      endcase
    end
    e.mini = 4'(cls);
    e.ill  = (cls == 15);
    e.alu  = (cls == 0 || cls == 11) ? 2'd1 : (cls == 6) ? 2'd2 : (cls == 2) ? 2'd3 : 2'd0;
    v = 0;
    e.sel = 3'd0;
    if (cls == 1 || cls == 2 || cls == 3 || cls == 9 || cls == 10) begin
      v = int'($signed(w[31:20]));
    end else if (cls == 4) begin
      e.sel = 3'd1;
      v = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
    end else if (cls == 5) begin
      e.sel = 3'd2;
      v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    end else if (cls == 6 || cls == 7) begin
      e.sel = 3'd3;
      v = int'(w[31:12]) * 4096;
    end else if (cls == 8) begin
      e.sel = 3'd4;
      v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
          + int'(w[30:21]) * 2;
    end
    e.imm = 32'(v);
    return e;
  endfunction

  task automatic cmp_f(input string tag, input f_t act, input f_t exp);
    chk({tag, "_pc"}, 64'(act.pc), 64'(exp.pc));
    chk({tag, "_rd"}, 64'(act.rd), 64'(exp.rd));
    chk({tag, "_rs1"}, 64'(act.rs1), 64'(exp.rs1));
    chk({tag, "_rs2"}, 64'(act.rs2), 64'(exp.rs2));
    chk({tag, "_funct3"}, 64'(act.f3), 64'(exp.f3));
    chk({tag, "_mini_op"}, 64'(act.mini), 64'(exp.mini));
    chk({tag, "_alu_op"}, 64'(act.alu), 64'(exp.alu));
    chk({tag, "_imm_sel"}, 64'(act.sel), 64'(exp.sel));
    chk({tag, "_imm"}, 64'(act.imm), 64'(exp.imm));
    chk({tag, "_illegal"}, 64'(act.ill), 64'(exp.ill));
  endtask

  // Model update: queue length is the buffer occupancy
  always @(posedge clk) begin
    f_t ea, eb;
    bit pop, acc;
    if (!rst_n) begin
      sbq.delete();
      m_cnt_a = 0; m_cnt_b = 0;
      disp_a = '0; disp_b = '0;
      started = 1;
    end else if (started) begin
      if (flush) begin
        sbq.delete();
      end else begin
        pop = (sbq.size() != 0) && out_ready;
        acc = in_valid && (sbq.size() <= 1);
        if (pop) void'(sbq.pop_front());
        if (acc) begin
          sbq.push_back('{w: in_instr, pc: in_pc});
          ea = ref_decode(in_instr, in_pc, 1'b1, 1'b1);
          eb = ref_decode(in_instr, in_pc, 1'b0, 1'b0);
          if (ea.ill && m_cnt_a < 255) m_cnt_a++;
          if (eb.ill && m_cnt_b < 3) m_cnt_b++;
        end
      end
    end
  end

  // Monitor: compare both instances against the model every cycle
  always @(negedge clk) begin
    f_t act_a, act_b;
    if (started) begin
      if (sbq.size() != 0) begin
        disp_a = ref_decode(sbq[0].w, sbq[0].pc, 1'b1, 1'b1);
        disp_b = ref_decode(sbq[0].w, sbq[0].pc, 1'b0, 1'b0);
      end
      chk("a_out_valid", 64'(a_out_valid), 64'(sbq.size() != 0));
      chk("b_out_valid", 64'(b_out_valid), 64'(sbq.size() != 0));
      chk("a_in_ready", 64'(a_in_ready), 64'(sbq.size() <= 1));
      chk("b_in_ready", 64'(b_in_ready), 64'(sbq.size() <= 1));
      chk("a_illegal_cnt", 64'(a_cnt), 64'(m_cnt_a));
      chk("b_illegal_cnt", 64'(b_cnt), 64'(m_cnt_b));
      act_a = '{pc: a_pc, rd: a_rd, rs1: a_rs1, rs2: a_rs2, f3: a_f3, mini: a_mini,
                alu: a_alu, sel: a_sel, imm: a_imm, ill: a_ill};
      act_b = '{pc: b_pc, rd: b_rd, rs1: b_rs1, rs2: b_rs2, f3: b_f3, mini: b_mini,
                alu: b_alu, sel: b_sel, imm: b_imm, ill: b_ill};
      cmp_f("a", act_a, disp_a);
      cmp_f("b", act_b, disp_b);
    end
  end

  always begin
    @(posedge clk);
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    int guard;
    if (aborted) return;
    in_valid = 1'b1; in_instr = w; in_pc = pc;
    guard = 0;
    @(negedge clk);
    while (!a_in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready got 0, want 1 within 200 cycles");
      aborted = 1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] w);
    flush = 1'b1; in_valid = 1'b1; in_instr = w;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n, input bit with_flush);
    rst_n = 1'b0; flush = with_flush; in_valid = 1'b1; in_instr = 32'h0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    logic [4:0]  opc;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: opc = 5'b01100;  1: opc = 5'b00000;  2: opc = 5'b00100;  3: opc = 5'b11001;
      4: opc = 5'b01000;  5: opc = 5'b11000;  6: opc = 5'b01101;  7: opc = 5'b00101;
      8: opc = 5'b11011;  9: opc = 5'b11100; 10: opc = 5'b00011;
      default: return w;
    endcase
    w[6:2] = opc;
    w[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
    if (opc == 5'b01100) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    int r;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rdy_mode = 1'b0; rdy_force = 1'b1; rnd_rdy = 1'b1;
    do_reset(3, 1'b0);
    chk("reset_out_valid", 64'(a_out_valid), 64'd0);
    chk("reset_in_ready", 64'(a_in_ready), 64'd1);
    chk("reset_out_pc", 64'(a_pc), 64'd0);

    send(32'h00500093, 32'h100);
    chk("addi_valid", 64'(a_out_valid), 64'd1);
    chk("addi_mini", 64'(a_mini), 64'h2);
    chk("addi_alu", 64'(a_alu), 64'h3);
    chk("addi_sel", 64'(a_sel), 64'h0);
    chk("addi_imm", 64'(a_imm), 64'd5);
    chk("addi_rd", 64'(a_rd), 64'd1);
    send(32'h12345137, 32'h104);
    chk("lui_mini", 64'(a_mini), 64'h6);
    chk("lui_alu", 64'(a_alu), 64'h2);
    chk("lui_sel", 64'(a_sel), 64'h3);
    chk("lui_imm", 64'(a_imm), 64'h12345000);
    send(32'hFE000EE3, 32'h108);
    chk("beq_mini", 64'(a_mini), 64'h5);
    chk("beq_sel", 64'(a_sel), 64'h2);
    chk("beq_imm", 64'(a_imm), 64'hFFFFFFFC);
    send(32'h022081B3, 32'h10C);
    chk("mul_a_mini", 64'(a_mini), 64'hB);
    chk("mul_a_alu", 64'(a_alu), 64'h1);
    chk("mul_b_illegal", 64'(b_ill), 64'd1);
    chk("mul_b_cnt", 64'(b_cnt), 64'd1);
    @(posedge clk);
    #1;

    // Backpressure: three words offered, only two fit
    rdy_force = 1'b0;
    fork
      begin
        send(32'h002081B3, 32'h200);
        send(32'h00A00113, 32'h204);
        send(32'h0020A423, 32'h208);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        chk("bp_out_valid", 64'(a_out_valid), 64'd1);
        chk("bp_head_pc", 64'(a_pc), 64'h200);
        rdy_force = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 64'(a_out_valid), 64'd0);

    // Saturating counter from a fresh reset
    do_reset(2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(32'h0, 32'h300 + 32'(i * 4));
      chk("zero_b_cnt", 64'(b_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
      chk("zero_a_cnt", 64'(a_cnt), 64'(i + 1));
    end
    for (int i = 0; i < 260; i++) send(32'h0, 32'h400);
    chk("a_cnt_sat", 64'(a_cnt), 64'd255);
    @(posedge clk);
    #1;

    // Flush with two entries buffered; the word offered during flush is dropped
    rdy_force = 1'b0;
    send(32'h00500093, 32'h500);
    send(32'h00600113, 32'h504);
    chk("fl_in_ready_full", 64'(a_in_ready), 64'd0);
    do_flush(32'h0);
    chk("fl_out_valid", 64'(a_out_valid), 64'd0);
    chk("fl_in_ready", 64'(a_in_ready), 64'd1);
    chk("fl_b_cnt", 64'(b_cnt), 64'd3);
    chk("fl_a_cnt", 64'(a_cnt), 64'd255);
    chk("fl_hold_pc", 64'(a_pc), 64'h500);

    // Reset mid-stream, asserted together with flush
    send(32'h00700193, 32'h600);
    send(32'h0, 32'h604);
    do_reset(1, 1'b1);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_pc", 64'(a_pc), 64'd0);
    chk("rst_imm", 64'(a_imm), 64'd0);

    rdy_mode = 1'b1;
    for (int i = 0; i < 1500 && !aborted; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_flush(gen_word());
      end else if (r == 2) begin
        do_reset(1, 1'($urandom_range(0, 1)));
      end else begin
        if (r < 15) begin
          @(posedge clk);
          #1;
        end
        send(gen_word(), $urandom);
      end
    end
    rdy_mode = 1'b0;
    rdy_force = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("final_drained", 64'(a_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
